// File: rtl/alu_mul_sequencer.sv
// Repeated-addition 8x8 unsigned multiplier that drives a shared combinational ALU.
// It alternates ADD (acc += mcand) and DEC (count -= 1) until the ALU reports a zero count.
module alu_mul_sequencer #(
    parameter int DATA_W        = 8,
    parameter bit SWAP_OPERANDS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product,
    output logic              ovf,
    output logic              zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_nzvc
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_DEC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DEC,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] count_q;
    logic              ovf_acc_q;

    logic [DATA_W-1:0] mcand_d;
    logic [DATA_W-1:0] count_d;

    // N and V flags play no part in the multiply.
    logic unused_flags;
    assign unused_flags = alu_nzvc[3] ^ alu_nzvc[1];

    // Using the smaller operand as the loop count minimises the number of ADD/DEC pairs.
    always_comb begin
        mcand_d = op_a;
        count_d = op_b;
        if (SWAP_OPERANDS && (op_a < op_b)) begin
            mcand_d = op_b;
            count_d = op_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            ovf_acc_q <= 1'b0;
            product   <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= ALU_ADD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q   <= mcand_d;
                        count_q   <= count_d;
                        acc_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        if (count_d == '0) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                            product <= '0;
                            ovf     <= 1'b0;
                            zero    <= 1'b1;
                        end else begin
                            state_q <= S_ADD;
                            busy    <= 1'b1;
                            alu_a   <= '0;
                            alu_b   <= mcand_d;
                            alu_sel <= ALU_ADD;
                        end
                    end
                end
                S_ADD: begin
                    acc_q     <= alu_result;
                    ovf_acc_q <= ovf_acc_q | alu_nzvc[0];
                    state_q   <= S_DEC;
                    alu_a     <= count_q;
                    alu_b     <= '0;
                    alu_sel   <= ALU_DEC;
                end
                S_DEC: begin
                    count_q <= alu_result;
                    // Z on the decrement means the loop count just reached zero.
                    if (alu_nzvc[2]) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc_q;
                        ovf     <= ovf_acc_q;
                        zero    <= (acc_q == '0);
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_sel <= ALU_ADD;
                    end else begin
                        state_q <= S_ADD;
                        alu_a   <= acc_q;
                        alu_b   <= mcand_q;
                        alu_sel <= ALU_ADD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, cycle-level reference model, literal and random ops.
// The model tracks only "cycles since start" and derives every output from closed-form arithmetic.
module tb_alu_mul_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic       busy, done, ovf, zero;
    logic [7:0] product, alu_a, alu_b, alu_result;
    logic [1:0] alu_sel;
    logic [3:0] alu_nzvc;
    logic [8:0] alu_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.DATA_W(8), .SWAP_OPERANDS(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .ovf(ovf), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_nzvc(alu_nzvc)
    );

    // 8-bit ALU: 00 ADD, 01 INC, 10 SUB, 11 DEC; flags {N,Z,V,C}
    always_comb begin
        alu_sum = 9'd0;
        case (alu_sel)
            2'b00: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: alu_sum = {1'b0, alu_a} + 9'd1;
            2'b10: alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_sum = {1'b0, alu_a} - 9'd1;
        endcase
    end
    assign alu_result = alu_sum[7:0];
    assign alu_nzvc   = {alu_sum[7], alu_sum[7:0] == 8'd0, 1'b0, alu_sum[8]};

    // Reference model: phase = cycles since the accepted start edge
    logic m_act = 1'b0;
    int   m_ph = 0, m_n = 0, m_mc = 0, m_full = 0;
    int   h_prod = 0;
    logic h_ovf = 1'b0, h_zero = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_ph <= 0; m_n <= 0; m_mc <= 0; m_full <= 0;
            h_prod <= 0; h_ovf <= 1'b0; h_zero <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act  <= 1'b1;
                m_ph   <= 1;
                m_n    <= (op_a < op_b) ? int'(op_a) : int'(op_b);
                m_mc   <= (op_a < op_b) ? int'(op_b) : int'(op_a);
                m_full <= int'(op_a) * int'(op_b);
                if (op_a == 8'd0 || op_b == 8'd0) begin
                    h_prod <= 0; h_ovf <= 1'b0; h_zero <= 1'b1;
                end
            end
        end else if (m_ph == 2 * m_n + 1) begin
            m_act <= 1'b0;
        end else begin
            m_ph <= m_ph + 1;
            if (m_ph + 1 == 2 * m_n + 1) begin
                h_prod <= m_full % 256;
                h_ovf  <= (m_full > 255);
                h_zero <= (m_full % 256 == 0);
            end
        end
    end

    function automatic logic e_busy();
        return m_act && (m_ph <= 2 * m_n);
    endfunction
    function automatic logic e_done();
        return m_act && (m_ph == 2 * m_n + 1);
    endfunction
    function automatic int e_sel();
        if (!e_busy()) return 0;
        return (m_ph % 2 == 1) ? 0 : 3;
    endfunction
    function automatic int e_alu_a();
        if (!e_busy()) return 0;
        if (m_ph % 2 == 1) return (m_mc * ((m_ph - 1) / 2)) % 256;
        return m_n - m_ph / 2 + 1;
    endfunction
    function automatic int e_alu_b();
        return (e_busy() && (m_ph % 2 == 1)) ? m_mc : 0;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        check("busy", int'(busy), int'(e_busy()));
        check("done", int'(done), int'(e_done()));
        check("product", int'(product), h_prod);
        check("ovf", int'(ovf), int'(h_ovf));
        check("zero", int'(zero), int'(h_zero));
        check("alu_sel", int'(alu_sel), e_sel());
        check("alu_a", int'(alu_a), e_alu_a());
        check("alu_b", int'(alu_b), e_alu_b());
    end

    task automatic run_op(input int a, input int b, input bit noise,
                          input int ep, input int eo, input int ez, input int el);
        int c;
        op_a  = 8'(a);
        op_b  = 8'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 600) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op_a  = 8'($urandom);
                op_b  = 8'($urandom);
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check("op_latency", c, el);
        check("op_product", int'(product), ep);
        check("op_ovf", int'(ovf), eo);
        check("op_zero", int'(zero), ez);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);
        check("rst_alu_sel", int'(alu_sel), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(5, 3, 1'b0, 15, 0, 0, 7);
        run_op(77, 0, 1'b0, 0, 0, 1, 1);
        run_op(16, 16, 1'b0, 0, 1, 1, 33);
        run_op(200, 2, 1'b0, 144, 1, 0, 5);
        run_op(9, 7, 1'b1, 63, 0, 0, 15);
        run_op(3, 4, 1'b0, 12, 0, 0, 7);

        for (int i = 0; i < 30; i++) begin
            int a, b, p, n;
            a = $urandom_range(0, 255);
            b = (i % 3 == 0) ? $urandom_range(0, 8) : $urandom_range(0, 255);
            p = a * b;
            n = (a < b) ? a : b;
            run_op(a, b, i[0], p % 256, int'(p > 255), int'(p % 256 == 0), 2 * n + 1);
        end

        // asynchronous reset while in DEC
        op_a  = 8'd50;
        op_b  = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_alu_sel", int'(alu_sel), 3);
        #2 rst = 1'b1;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_product", int'(product), 0);
        check("async_alu_a", int'(alu_a), 0);
        check("async_alu_sel", int'(alu_sel), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(255, 1, 1'b0, 255, 0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle unsigned 8x8 multiplier that drives the 8-bit arithmetic unit as its initiator.
- Computes the product by repeated addition: it alternates an ADD of the multiplicand into an accumulator with a DEC of the loop counter, all through the one shared ALU.
- Sits between the datapath control and the ALU, owning the ALU_Sel/A/B inputs while busy.
- Returns an 8-bit truncated product with overflow and zero status.

Parameters:
- DATA_W, 8, operand/ALU width; fixed at 8 to match the ALU.
- SWAP_OPERANDS, 1, if 1 the smaller operand becomes the loop count (shorter latency); if 0 op_b is always the count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  8  operand A (unsigned).
- op_b  input  8  operand B (unsigned).
- busy  output  1  high in ADD and DEC states.
- done  output  1  one-cycle pulse in DONE state.
- product  output  8  registered product, low 8 bits.
- ovf  output  1  registered; true product > 255.
- zero  output  1  registered; product == 0.
- alu_a  output  8  to ALU operand A.
- alu_b  output  8  to ALU operand B.
- alu_sel  output  2  to ALU selector (00 ADD, 01 INC, 10 SUB, 11 DEC).
- alu_result  input  8  ALU result.
- alu_nzvc  input  4  ALU flags {N,Z,V,C}; C = carry-out on ADD, Z = result zero.

Behaviour:
- Reset (async, active-high): state=IDLE; acc, mcand, count, product, ovf, zero, busy, done all 0; alu_sel=00, alu_a=0, alu_b=0.
- The ALU is combinational; each ALU result is captured on the same clock edge that ends its state.
- IDLE: alu_a=0, alu_b=0, alu_sel=00. On start:
  - Load mcand and count. With SWAP_OPERANDS=1, count=min(op_a,op_b) and mcand=max(op_a,op_b). Otherwise mcand=op_a and count=op_b.
  - Clear acc and the sticky ovf accumulator.
  - If count==0, go to DONE. Otherwise go to ADD.
- ADD: alu_a=acc, alu_b=mcand, alu_sel=00. At the edge: acc<=alu_result; ovf_acc<=ovf_acc|alu_nzvc[0]. Next state is DEC.
- DEC: alu_a=count, alu_b=0, alu_sel=11. At the edge: count<=alu_result. If alu_nzvc[2]==1, go to DONE. Otherwise go to ADD.
- On entry to DONE, at the same edge: product<=acc (or the just-captured result); ovf<=ovf_acc; zero<=(product value==0).
- DONE: done=1 for exactly one cycle, then IDLE. product/ovf/zero hold until the next DONE entry.
- Latency: start sampled at cycle 0 gives done in cycle 2N+1 (N=loop count). N=0 gives done in cycle 1, with no ADD issued.
- busy=1 only in ADD/DEC. start is ignored in ADD, DEC and DONE; no queuing.
- Operands are latched at the start edge; later op_a/op_b changes have no effect.
- Overflow: any ADD carry sets ovf sticky for the operation. product is the result modulo 256.
- Wrap-around: acc wraps naturally through the ALU. count never underflows because DEC exits on Z.
- Reset mid-operation: immediate return to IDLE; all outputs cleared; no done pulse.
- The ALU V flag and N flag are not used.

Test Plan:
- SWAP=0, op_a=5, op_b=3, start 1 cycle -> ADD/DEC alternate 3 times; done in cycle 7; product=15, ovf=0, zero=0.
- op_b=0, op_a=77 -> done in cycle 1, alu_sel never 00 with nonzero alu_b; product=0, zero=1, ovf=0.
- op_a=16, op_b=16 -> product=0, ovf=1, zero=1, done in cycle 33 (SWAP=1, N=16).
- SWAP=1, op_a=200, op_b=2 -> count=2; product=144, ovf=1; done in cycle 5.
- start pulsed again during busy with different operands -> ignored; result matches the first operands. A subsequent start in IDLE is accepted.
- rst asserted asynchronously mid-DEC -> outputs 0 immediately, state IDLE, no done pulse. The next start of 255*1 gives product=255, ovf=0, done in cycle 3.
